// File: rtl/chess_display_driver.sv
// Eight-digit multiplexed 7-segment driver for two MM.SS chess clocks.
// Frame-level input snapshot, per-slot anti-ghost blanking, expiry blink.
module chess_display_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_DIV    = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] player,
  input  logic [5:0] min1,
  input  logic [5:0] sec1,
  input  logic [5:0] min2,
  input  logic [5:0] sec2,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] slot_cnt;
  logic [2:0]    dig;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [5:0]    sh_min1, sh_sec1, sh_min2, sh_sec2;

  logic          tick;
  logic [5:0]    sec1_c, sec2_c;
  logic [3:0]    nib;
  logic          exp1, exp2, hide;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    logic [3:0] t;
    t = '0;
    for (int unsigned k = 1; k <= 6; k++)
      if (v >= 6'(k * 10)) t = 4'(k);
    return t;
  endfunction

  function automatic logic [3:0] units_of(input logic [5:0] v);
    return 4'(v - ({2'b00, tens_of(v)} * 6'd10));
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign tick = (slot_cnt == SLOT_LAST);

  always_comb begin
    sec1_c = (sh_sec1 > 6'd59) ? 6'd59 : sh_sec1;
    sec2_c = (sh_sec2 > 6'd59) ? 6'd59 : sh_sec2;
    case (dig)
      3'd7:    nib = tens_of(sh_min1);
      3'd6:    nib = units_of(sh_min1);
      3'd5:    nib = tens_of(sec1_c);
      3'd4:    nib = units_of(sec1_c);
      3'd3:    nib = tens_of(sh_min2);
      3'd2:    nib = units_of(sh_min2);
      3'd1:    nib = tens_of(sec2_c);
      default: nib = units_of(sec2_c);
    endcase
    seg_next = seg_code(nib);
    exp1 = (sh_min1 == 6'd0) && (sh_sec1 == 6'd0);
    exp2 = (sh_min2 == 6'd0) && (sh_sec2 == 6'd0);
    // dig[2] separates player 1's half (7..4) from player 2's (3..0)
    hide = (slot_cnt < BLANK_END) ||
           (enable && blink_phase && (dig[2] ? exp1 : exp2));
    an_next = '1;
    if (!hide) an_next[dig] = 1'b0;
    dp_next = !(!hide && enable &&
                ((dig == 3'd6 && player == 2'b01) ||
                 (dig == 3'd2 && player == 2'b10)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_cnt    <= '0;
      dig         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      sh_min1     <= '0;
      sh_sec1     <= '0;
      sh_min2     <= '0;
      sh_sec2     <= '0;
      an          <= '1;
      seg         <= '1;
      dp          <= 1'b1;
    end else begin
      slot_cnt <= tick ? '0 : slot_cnt + 1'b1;
      if (tick) begin
        dig <= dig + 1'b1;
        if (dig == 3'd7) begin
          sh_min1 <= min1;
          sh_sec1 <= sec1;
          sh_min2 <= min2;
          sh_sec2 <= sec2;
        end
      end
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_chess_display_driver.sv
// Bench for chess_display_driver: cycle-level reference model feeding a
// scoreboard queue, plus per-scenario frame captures against literal codes.
module tb_chess_display_driver;
  localparam int RD = 4;
  localparam int BC = 1;
  localparam int BD = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] player = 2'b00;
  logic [5:0] min1 = '0, sec1 = '0, min2 = '0, sec2 = '0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  chess_display_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .player(player),
    .min1(min1), .sec1(sec1), .min2(min2), .sec2(sec2),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q [$];
  logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int m_slot = 0, m_dig = 0, m_bcnt = 0;
  bit m_phase = 1'b0;
  int m_min1 = 0, m_sec1 = 0, m_min2 = 0, m_sec2 = 0;

  // Reference model: predicts what the DUT registers at this edge.
  always @(posedge clk) begin : model
    int v, s1, s2;
    bit hide, expd, d;
    logic [7:0] a;
    if (!reset) begin
      exp_q.push_back({8'hFF, 7'h7F, 1'b1});
      m_slot = 0; m_dig = 0; m_bcnt = 0; m_phase = 1'b0;
      m_min1 = 0; m_sec1 = 0; m_min2 = 0; m_sec2 = 0;
    end else begin
      s1 = (m_sec1 > 59) ? 59 : m_sec1;
      s2 = (m_sec2 > 59) ? 59 : m_sec2;
      case (m_dig)
        0: v = s2 % 10;
        1: v = s2 / 10;
        2: v = m_min2 % 10;
        3: v = m_min2 / 10;
        4: v = s1 % 10;
        5: v = s1 / 10;
        6: v = m_min1 % 10;
        default: v = m_min1 / 10;
      endcase
      expd = (m_dig >= 4) ? (m_min1 == 0 && m_sec1 == 0) : (m_min2 == 0 && m_sec2 == 0);
      hide = (m_slot < BC) || (expd && enable && m_phase);
      a = 8'hFF;
      if (!hide) a[m_dig] = 1'b0;
      d = !(!hide && enable && ((m_dig == 6 && player == 2'b01) || (m_dig == 2 && player == 2'b10)));
      exp_q.push_back({a, seg_tab[v], d});
      if (m_slot == RD - 1) begin
        m_slot = 0;
        if (m_dig == 7) begin
          m_min1 = int'(min1); m_sec1 = int'(sec1);
          m_min2 = int'(min2); m_sec2 = int'(sec2);
        end
        m_dig = (m_dig + 1) % 8;
      end else begin
        m_slot++;
      end
      if (m_bcnt == BD - 1) begin
        m_bcnt = 0;
        m_phase = !m_phase;
      end else begin
        m_bcnt++;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 $time, an, seg, dp, e[15:8], e[7:1], e[0]);
      end
    end
  end

  logic [7:0] cap_an [8];
  logic [6:0] cap_seg [8];
  logic       cap_dp [8];
  logic [7:0] cap_blank [8];

  task automatic sync_frame;
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (an !== 8'h7F && n < 300);
    checks++;
    if (an !== 8'h7F) begin errors++; $display("FAIL sync_dig7 got an=%h want 7f", an); end
    n = 0;
    do begin @(negedge clk); n++; end while (an !== 8'hFF && n < 10);
    checks++;
    if (an !== 8'hFF) begin errors++; $display("FAIL sync_blank got an=%h want ff", an); end
  endtask

  // Entered on the blank cycle of digit 0; returns on the next frame's one.
  task automatic capture_frame(input int change_sec1_at);
    for (int d = 0; d < 8; d++) begin
      @(negedge clk);
      cap_an[d] = an; cap_seg[d] = seg; cap_dp[d] = dp;
      if (d == change_sec1_at) sec1 = 6'd45;
      repeat (3) @(negedge clk);
      cap_blank[d] = an;
    end
  endtask

  task automatic test_reset;
    logic [7:0] wa;
    min1 = 6'd5; sec1 = 6'd30; min2 = 6'd12; sec2 = 6'd7;
    player = 2'b01; enable = 1'b0;
    repeat (13) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
        errors++;
        $display("FAIL reset_outputs got an=%h seg=%h dp=%b want ff 7f 1", an, seg, dp);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 8'hFF) begin errors++; $display("FAIL reset_first_blank got an=%h want ff", an); end
    capture_frame(-1);
    for (int d = 0; d < 8; d++) begin
      wa = 8'hFF; wa[d] = 1'b0;
      checks++;
      if (cap_seg[d] !== 7'h40 || cap_an[d] !== wa) begin
        errors++;
        $display("FAIL reset_frame d=%0d got an=%h seg=%h want an=%h seg=40", d, cap_an[d], cap_seg[d], wa);
      end
    end
  endtask

  task automatic test_display;
    logic [6:0] want [8];
    logic [7:0] wa;
    want = '{7'h78, 7'h40, 7'h24, 7'h79, 7'h40, 7'h30, 7'h12, 7'h40};
    enable = 1'b1; player = 2'b01;
    sync_frame();
    capture_frame(-1);
    for (int d = 0; d < 8; d++) begin
      wa = 8'hFF; wa[d] = 1'b0;
      checks++;
      if (cap_seg[d] !== want[d] || cap_an[d] !== wa || cap_dp[d] !== (d != 6) || cap_blank[d] !== 8'hFF) begin
        errors++;
        $display("FAIL display d=%0d got an=%h seg=%h dp=%b blank=%h want an=%h seg=%h dp=%b blank=ff",
                 d, cap_an[d], cap_seg[d], cap_dp[d], cap_blank[d], wa, want[d], d != 6);
      end
    end
  endtask

  task automatic test_snapshot;
    capture_frame(5);
    checks++;
    if (cap_seg[5] !== 7'h30 || cap_seg[4] !== 7'h40) begin
      errors++;
      $display("FAIL snapshot_hold got d5=%h d4=%h want 30 40", cap_seg[5], cap_seg[4]);
    end
    capture_frame(-1);
    checks++;
    if (cap_seg[5] !== 7'h19 || cap_seg[4] !== 7'h12) begin
      errors++;
      $display("FAIL snapshot_next got d5=%h d4=%h want 19 12", cap_seg[5], cap_seg[4]);
    end
  endtask

  task automatic test_clamp;
    sec2 = 6'd62;
    sync_frame();
    capture_frame(-1);
    checks++;
    if (cap_seg[1] !== 7'h12 || cap_seg[0] !== 7'h10) begin
      errors++;
      $display("FAIL clamp got d1=%h d0=%h want 12 10", cap_seg[1], cap_seg[0]);
    end
    sec2 = 6'd7;
  endtask

  task automatic test_expiry;
    int run, longest, lit;
    min2 = 6'd0; sec2 = 6'd0; enable = 1'b1;
    sync_frame();
    run = 0; longest = 0; lit = 0;
    for (int i = 0; i < 192; i++) begin
      @(negedge clk);
      if (an[3:0] === 4'hF) begin run++; if (run > longest) longest = run; end
      else begin run = 0; lit++; end
    end
    checks++;
    if (longest < 32 || lit == 0) begin
      errors++;
      $display("FAIL expiry_blink got longest_dark=%0d lit=%0d want >=32 and >0", longest, lit);
    end
    enable = 1'b0;
    run = 0; longest = 0; lit = 0;
    for (int i = 0; i < 192; i++) begin
      @(negedge clk);
      if (an[3:0] === 4'hF) begin run++; if (run > longest) longest = run; end
      else begin run = 0; lit++; end
    end
    checks++;
    if (longest >= 32 || lit == 0) begin
      errors++;
      $display("FAIL expiry_disabled got longest_dark=%0d lit=%0d want <32 and >0", longest, lit);
    end
    min2 = 6'd12; sec2 = 6'd7; enable = 1'b1;
  endtask

  task automatic test_player;
    player = 2'b10;
    sync_frame();
    capture_frame(-1);
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (cap_dp[d] !== (d != 2)) begin
        errors++;
        $display("FAIL player2_dp d=%0d an=%h got dp=%b want %b", d, cap_an[d], cap_dp[d], d != 2);
      end
    end
    checks++;
    if (cap_an[2] !== 8'hFB) begin errors++; $display("FAIL player2_an got an=%h want fb", cap_an[2]); end
    player = 2'b11;
    sync_frame();
    capture_frame(-1);
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (cap_dp[d] !== 1'b1) begin
        errors++;
        $display("FAIL player11_dp d=%0d got dp=%b want 1", d, cap_dp[d]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_display();
    test_snapshot();
    test_clamp();
    test_expiry();
    test_player();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
